// File: rtl/bitonic_input_packer.sv
// bitonic_input_packer: packs a serial element stream into padded frames for the bitonic sorter.
module bitonic_input_packer #(
    parameter int DATA_WIDTH = 4,
    parameter int LOG_INPUT  = 5,
    parameter int ASCENDING  = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DATA_WIDTH-1:0]                      in_data,
    input  logic                                       in_valid,
    input  logic                                       in_last,
    input  logic                                       flush,
    output logic                                       in_ready,
    output logic [0:DATA_WIDTH*(2**LOG_INPUT)-1]       y,
    output logic                                       y_valid,
    output logic [LOG_INPUT:0]                         y_count
);
    localparam int N = 2**LOG_INPUT;
    localparam logic [DATA_WIDTH-1:0] pad = (ASCENDING != 0) ? '1 : '0;

    logic [LOG_INPUT-1:0]             cnt;
    logic [N-1:0][DATA_WIDTH-1:0]     frame;
    logic [0:DATA_WIDTH*N-1]          y_next;
    logic                             flushing, accept, close;

    // a pending flush steals the cycle, so the offered element stays with the source
    assign flushing = flush && cnt != '0;
    assign in_ready = !rst && !flushing;
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_last || cnt == LOG_INPUT'(N-1));

    always_comb begin
        y_next = '0;
        for (int i = 0; i < N; i++)
            y_next[i*DATA_WIDTH +: DATA_WIDTH] = i < int'(cnt) ? frame[i] :
                (i == int'(cnt) && !flushing) ? in_data : pad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            frame   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            y_count <= '0;
        end else begin
            y_valid <= close || flushing;
            if (accept)
                frame[cnt] <= in_data;
            if (close || flushing) begin
                y       <= y_next;
                y_count <= flushing ? {1'b0, cnt} : {1'b0, cnt} + (LOG_INPUT+1)'(1);
                cnt     <= '0;
            end else if (accept) begin
                cnt <= cnt + LOG_INPUT'(1);
            end
        end
    end
endmodule

// File: tb/tb_bitonic_input_packer.sv
// tb_bitonic_input_packer: directed checks of framing, padding, flush and reset behaviour (N=4).
module tb_bitonic_input_packer;
    logic        clk = 0, rst = 1;
    logic [3:0]  in_data = '0;
    logic        in_valid = 0, in_last = 0, flush = 0;
    logic        in_ready, y_valid, in_ready_d, y_valid_d;
    logic [0:15] y, y_d;
    logic [2:0]  y_count, y_count_d;
    int tests = 0, fails = 0;

    bitonic_input_packer #(.DATA_WIDTH(4), .LOG_INPUT(2), .ASCENDING(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .flush(flush), .in_ready(in_ready), .y(y), .y_valid(y_valid), .y_count(y_count));

    bitonic_input_packer #(.DATA_WIDTH(4), .LOG_INPUT(2), .ASCENDING(0)) dut_d (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .flush(flush), .in_ready(in_ready_d), .y(y_d), .y_valid(y_valid_d), .y_count(y_count_d));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        in_data = d; in_valid = 1; in_last = l;
        #1 chk("ready_on_send", in_ready, 1);
        tick();
        in_valid = 0; in_last = 0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_y", y, 0);
        chk("rst_yvalid", y_valid, 0);
        chk("rst_ycount", y_count, 0);
        rst = 0;
        #1 chk("ready_after_rst", in_ready, 1);
        // single full frame
        send(4'h3, 0); send(4'h1, 0); send(4'h4, 0);
        chk("no_early_pulse", y_valid, 0);
        send(4'h2, 0);
        chk("f1_valid", y_valid, 1);
        chk("f1_y", y, 16'h3142);
        chk("f1_count", y_count, 4);
        tick();
        chk("f1_pulse_one_cycle", y_valid, 0);
        chk("f1_y_hold", y, 16'h3142);
        // back-to-back frames
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
        chk("b2b_a_valid", y_valid, 1);
        chk("b2b_a_y", y, 16'h1234);
        send(4'h5, 0);
        chk("b2b_gap1", y_valid, 0);
        send(4'h6, 0); send(4'h7, 0);
        chk("b2b_gap3", y_valid, 0);
        send(4'h8, 0);
        chk("b2b_b_valid", y_valid, 1);
        chk("b2b_b_y", y, 16'h5678);
        chk("b2b_b_count", y_count, 4);
        // short frame via in_last, both pad polarities
        send(4'h7, 0); send(4'h2, 1);
        chk("last_valid", y_valid, 1);
        chk("last_y_asc", y, 16'h72FF);
        chk("last_count", y_count, 2);
        chk("last_y_desc", y_d, 16'h7200);
        chk("last_valid_desc", y_valid_d, 1);
        // flush with partial frame holds off the offered element
        send(4'h5, 0);
        in_data = 4'h9; in_valid = 1; flush = 1;
        #1 chk("flush_ready_low", in_ready, 0);
        tick();
        chk("flush_valid", y_valid, 1);
        chk("flush_y", y, 16'h5FFF);
        chk("flush_count", y_count, 1);
        flush = 0;
        #1 chk("flush_ready_back", in_ready, 1);
        tick();
        in_valid = 0;
        chk("flush_pulse_one_cycle", y_valid, 0);
        send(4'h8, 0); send(4'h7, 1);
        chk("retained_y", y, 16'h987F);
        chk("retained_count", y_count, 3);
        // flush on empty frame is a no-op
        tick();
        in_data = 4'h6; in_valid = 1; flush = 1;
        #1 chk("empty_flush_ready", in_ready, 1);
        tick();
        in_valid = 0; flush = 0;
        chk("empty_flush_no_pulse", y_valid, 0);
        send(4'h5, 1);
        chk("empty_flush_y", y, 16'h65FF);
        chk("empty_flush_count", y_count, 2);
        // reset mid-frame
        send(4'h1, 0); send(4'h2, 0);
        rst = 1;
        #1 chk("midrst_ready", in_ready, 0);
        tick();
        chk("midrst_no_pulse", y_valid, 0);
        rst = 0;
        send(4'hA, 0); send(4'hB, 0); send(4'hC, 0);
        chk("midrst_no_pulse2", y_valid, 0);
        send(4'hD, 1);
        chk("midrst_valid", y_valid, 1);
        chk("midrst_y", y, 16'hABCD);
        chk("midrst_count", y_count, 4);
        // async reset takes effect before the next edge
        #2 rst = 1;
        #1;
        chk("async_yvalid", y_valid, 0);
        chk("async_ready", in_ready, 0);
        chk("async_y", y, 0);
        tick();
        rst = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bitonic_input_packer.md
Name: bitonic_input_packer

Overview:
- Serial-to-parallel front end for the bitonic sorting network.
- Accepts one DATA_WIDTH element per cycle over a valid/ready handshake and packs 2**LOG_INPUT elements into one frame.
- Presents the frame to the sorter's x/x_valid inputs as a one-cycle valid pulse.
- Short frames, ended by in_last or flush, are padded so that padding sorts to the tail.

Parameters:
- DATA_WIDTH, 4, bits per element.
- LOG_INPUT, 5, log2 of elements per frame (N = 2**LOG_INPUT).
- ASCENDING, 1, must match the sorter. Pad value is all-ones when 1, all-zeros when 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  element.
- in_valid  input  1  in_data is valid.
- in_last  input  1  qualified by in_valid; marks the final element of a frame.
- flush  input  1  force emission of the partially filled frame.
- in_ready  output  1  element accepted on the edge where in_valid && in_ready.
- y  output  DATA_WIDTH*N  packed frame, index [0:DATA_WIDTH*N-1]; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH], so element 0 sits at the MSB end. Connects to the sorter's x.
- y_valid  output  1  single-cycle frame strobe. Connects to the sorter's x_valid.
- y_count  output  LOG_INPUT+1  number of real (non-pad) elements in y, range 1..N.

Behaviour:
- Reset (async assert, sync release): cnt=0, frame register=0, y=0, y_valid=0, y_count=0. in_ready is 0 while rst is high.
- in_ready = !rst && !(flush && cnt!=0). The block never back-pressures for any other reason, so sustained throughput is one element per cycle with no inter-frame bubble.
- Accept (in_valid && in_ready): element is written to slot cnt.
  - If cnt==N-1 or in_last: close the frame.
  - Otherwise: cnt <= cnt+1.
- Close on the same edge:
  - y <= frame, with slots 0..cnt-1 from the register, slot cnt = in_data, and slots cnt+1..N-1 = pad.
  - y_count <= cnt+1; y_valid <= 1; cnt <= 0.
  - Latency: last element accepted at edge k gives y_valid high during cycle k+1.
- Flush when cnt!=0:
  - in_ready=0 and in_valid is ignored (the element is not consumed and the source retains it).
  - y <= frame with slots cnt..N-1 = pad; y_count <= cnt; y_valid <= 1; cnt <= 0.
- Flush when cnt==0: no-op. in_ready stays 1 and an element may be accepted in that cycle.
- in_last on a slot-N-1 element: same as a normal full frame. No extra frame, no extra pad.
- y_valid is high for exactly one cycle per frame and is 0 in all other cycles.
- y and y_count hold their last values until the next close. The sorter has no back-pressure, so the block never stalls y_valid.
- The frame register is not cleared between frames. Stale slots are always overwritten by data or pad before emission.
- cnt wraps only through close (N-1 to 0). It never increments past N-1.
- Reset mid-frame discards the partial frame. No y_valid is produced for it.
- in_last without in_valid is ignored.

Test Plan (LOG_INPUT=2, DATA_WIDTH=4, N=4, ASCENDING=1 unless stated):
- Reset then stream 3,1,4,2 on 4 consecutive cycles -> one y_valid pulse on the cycle after the 4th accept; y=16'h3142, y_count=4; in_ready stays 1 throughout.
- Back-to-back frames 1,2,3,4,5,6,7,8 with no gaps -> y_valid pulses exactly 4 cycles apart; y=16'h1234 then 16'h5678; no element dropped.
- Stream 7,2 with in_last on 2 -> y=16'h72FF, y_count=2. Repeat with ASCENDING=0 -> y=16'h7200.
- Accept 5, then assert flush together with in_valid carrying 9 -> in_ready=0 that cycle; y=16'h5FFF, y_count=1. Next cycle 9 is accepted into slot 0.
- flush with cnt==0 alongside in_valid=1 carrying 6 -> no y_valid; 6 lands in slot 0.
- Accept 1,2, assert rst for 1 cycle, then stream A,B,C,D -> no pulse for the partial frame; y=16'hABCD, y_count=4. Async check: rst asserted mid-cycle forces y_valid=0 and in_ready=0 before the next edge.
